gether_mac_rx: RTL and testbench



---
 rtl/gether_pkg.sv | 27 ++
 rtl/gether_mac_rx_if.sv | 23 ++
 rtl/crc32_d8.sv | 23 ++
 rtl/gether_mac_rx.sv | 164 ++++++++++++++++
 tb/tb_gether_mac_rx.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/gether_pkg.sv
// Shared constants and state type for the gigabit Ethernet MAC pair.
// Contents: framing bytes, CRC-32 constants, frame length limits, and the rx FSM state enum.
// Imported by gether_mac_rx and crc32_d8; the constants are shared with the transmit MAC.
package gether_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  // Reflected CRC-32 (IEEE 802.3), LSB-first shift register.
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

  // Frame length limits, counted in bytes after the SFD.
  localparam int MIN_FRAME = 64;
  localparam int HDR_LEN   = 14;
  localparam int FCS_LEN   = 4;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    PREAMBLE,
    BODY,
    DROP
  } rx_state_t;

endpackage

// File: rtl/gether_mac_rx_if.sv
// GMII receive pins plus the payload byte stream and frame status of the rx MAC.
// Signals: gmii_rx_dv/gmii_rx_er/gmii_rxd in; data_valid/data_out, end pulses and eth_type out.
// Modports: slave is the MAC side; master is the PHY / sink side (the testbench).
interface gether_mac_rx_if;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
  logic [7:0]  gmii_rxd;
  logic        data_valid;
  logic [7:0]  data_out;
  logic        data_frame_ready;
  logic        frame_err;
  logic [15:0] eth_type;

  modport slave (
    input  gmii_rx_dv, gmii_rx_er, gmii_rxd,
    output data_valid, data_out, data_frame_ready, frame_err, eth_type
  );

  modport master (
    output gmii_rx_dv, gmii_rx_er, gmii_rxd,
    input  data_valid, data_out, data_frame_ready, frame_err, eth_type
  );
endinterface

// File: rtl/crc32_d8.sv
// Combinational CRC-32 update for one byte, reflected polynomial, LSB first.
// Ports: crc (current register), data (incoming byte), crc_next (updated register).
// No inversion here; callers handle init value and final complement.
module crc32_d8
  import gether_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  logic [31:0] c;

  always_comb begin
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY_REFL;
      else                c = c >> 1;
    end
    crc_next = c;
  end

endmodule

// File: rtl/gether_mac_rx.sv
// Gigabit Ethernet receive MAC: strips preamble, SFD, 14-byte header and FCS; emits payload bytes.
// Ports: clk, rst (sync, active high), bus (slave: GMII in, payload byte strobe + end pulses out).
// Payload byte k appears on data_out one cycle after byte k+4 is sampled; no backpressure.
module gether_mac_rx
  import gether_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC   = 48'h02_00_00_00_00_01,
  parameter int          MAX_PAYLOAD = 1500
) (
  input  logic           clk,
  input  logic           rst,
  gether_mac_rx_if.slave bus
);

  localparam logic [10:0] CNT_MAX    = 11'h7FF;
  localparam logic [10:0] ADDR_LEN   = 11'd6;
  localparam logic [10:0] TYPE_HI    = 11'd12;
  localparam logic [10:0] TYPE_LO    = 11'd13;
  localparam logic [10:0] MIN_LEN    = 11'(MIN_FRAME);
  // First byte index whose arrival releases a payload byte from the delay line.
  localparam logic [10:0] FIRST_EMIT = 11'(HDR_LEN + FCS_LEN);
  // Byte index whose arrival would release payload byte number MAX_PAYLOAD+1.
  localparam logic [10:0] EMIT_END   = 11'(HDR_LEN + FCS_LEN + MAX_PAYLOAD);

  rx_state_t   state, state_nx;
  logic [10:0] byte_cnt;
  logic [31:0] crc, crc_nx;
  logic [7:0]  dly [4];
  logic        uni_ok, bc_ok, rxerr, over;
  logic        uni_nx, bc_nx, in_addr, addr_bad;
  logic [7:0]  mac_byte;
  logic        sfd_hit, body_byte, frame_end, frame_good;

  logic        data_valid_q, frame_ready_q, frame_err_q;
  logic [7:0]  data_out_q;
  logic [15:0] eth_type_q;

  crc32_d8 u_crc (
    .crc      (crc),
    .data     (bus.gmii_rxd),
    .crc_next (crc_nx)
  );

  // Destination check: unicast and broadcast are tracked independently so a
  // mix such as FF,00,.. is rejected.
  always_comb begin
    mac_byte = 8'h00;
    case (byte_cnt[2:0])
      3'd0:    mac_byte = LOCAL_MAC[47:40];
      3'd1:    mac_byte = LOCAL_MAC[39:32];
      3'd2:    mac_byte = LOCAL_MAC[31:24];
      3'd3:    mac_byte = LOCAL_MAC[23:16];
      3'd4:    mac_byte = LOCAL_MAC[15:8];
      3'd5:    mac_byte = LOCAL_MAC[7:0];
      default: mac_byte = 8'h00;
    endcase
    in_addr  = byte_cnt < ADDR_LEN;
    uni_nx   = uni_ok && (bus.gmii_rxd == mac_byte);
    bc_nx    = bc_ok && (bus.gmii_rxd == 8'hFF);
    addr_bad = in_addr && !uni_nx && !bc_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      WAIT_IDLE: if (!bus.gmii_rx_dv) state_nx = IDLE;
      IDLE: begin
        if (bus.gmii_rx_dv)
          state_nx = (bus.gmii_rxd == PREAMBLE_BYTE) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!bus.gmii_rx_dv)                     state_nx = IDLE;
        else if (bus.gmii_rxd == SFD_BYTE)       state_nx = BODY;
        else if (bus.gmii_rxd != PREAMBLE_BYTE)  state_nx = DROP;
      end
      BODY: begin
        if (!bus.gmii_rx_dv) state_nx = IDLE;
        else if (addr_bad)   state_nx = DROP;
      end
      DROP:    if (!bus.gmii_rx_dv) state_nx = IDLE;
      default: state_nx = WAIT_IDLE;
    endcase
  end

  // A frame that ends before its destination was fully checked was never
  // accepted, so it ends silently.
  always_comb begin
    sfd_hit   = (state == PREAMBLE) && bus.gmii_rx_dv && (bus.gmii_rxd == SFD_BYTE);
    body_byte = (state == BODY) && bus.gmii_rx_dv;
    frame_end = (state == BODY) && !bus.gmii_rx_dv && (byte_cnt >= ADDR_LEN);
  end

  assign frame_good = (crc == CRC_RESIDUE) && (byte_cnt >= MIN_LEN) && !rxerr && !over;

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt      <= '0;
      crc           <= CRC_INIT;
      uni_ok        <= 1'b0;
      bc_ok         <= 1'b0;
      rxerr         <= 1'b0;
      over          <= 1'b0;
      for (int i = 0; i < 4; i++) dly[i] <= 8'h00;
      data_valid_q  <= 1'b0;
      data_out_q    <= 8'h00;
      frame_ready_q <= 1'b0;
      frame_err_q   <= 1'b0;
      eth_type_q    <= 16'h0000;
    end else begin
      data_valid_q  <= 1'b0;
      frame_ready_q <= 1'b0;
      frame_err_q   <= 1'b0;

      if (sfd_hit) begin
        byte_cnt <= '0;
        crc      <= CRC_INIT;
        uni_ok   <= 1'b1;
        bc_ok    <= 1'b1;
        rxerr    <= 1'b0;
        over     <= 1'b0;
      end

      if (body_byte) begin
        crc    <= crc_nx;
        dly[0] <= bus.gmii_rxd;
        dly[1] <= dly[0];
        dly[2] <= dly[1];
        dly[3] <= dly[2];
        if (byte_cnt != CNT_MAX) byte_cnt <= byte_cnt + 11'd1;
        if (in_addr) begin
          uni_ok <= uni_nx;
          bc_ok  <= bc_nx;
        end
        if (byte_cnt == TYPE_HI) eth_type_q[15:8] <= bus.gmii_rxd;
        if (byte_cnt == TYPE_LO) eth_type_q[7:0]  <= bus.gmii_rxd;
        if (bus.gmii_rx_er) rxerr <= 1'b1;
        // dly[3] holds the byte four positions back, i.e. never an FCS byte.
        if (byte_cnt >= EMIT_END) begin
          over <= 1'b1;
        end else if (byte_cnt >= FIRST_EMIT && !over) begin
          data_valid_q <= 1'b1;
          data_out_q   <= dly[3];
        end
      end

      if (frame_end) begin
        frame_ready_q <= frame_good;
        frame_err_q   <= !frame_good;
      end
    end
  end

  assign bus.data_valid       = data_valid_q;
  assign bus.data_out         = data_out_q;
  assign bus.data_frame_ready = frame_ready_q;
  assign bus.frame_err        = frame_err_q;
  assign bus.eth_type         = eth_type_q;

endmodule

// File: tb/tb_gether_mac_rx.sv
// Randomized bench for gether_mac_rx against a frame-level reference model.
// Each frame is built as a byte list with its FCS; the model derives expected beats and end pulse.
module tb_gether_mac_rx;

  localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
  localparam int          MAXP  = 1500;

  logic clk = 1'b0;
  logic rst;
  always #4 clk = ~clk;

  gether_mac_rx_if bus ();

  gether_mac_rx #(
    .LOCAL_MAC   (MAC),
    .MAX_PAYLOAD (MAXP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  byte unsigned frm[$];
  byte unsigned got_q[$];
  int           ok_n, err_n, ok_at, err_at;
  logic [15:0]  et_at;

  // Bitwise IEEE CRC-32 over the first n bytes, returned as the FCS value.
  function automatic logic [31:0] fcs_of(input byte unsigned q[$], input int n);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      b = q[i];
      for (int j = 0; j < 8; j++)
        c = (c[0] ^ b[j]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build(input logic [47:0] dst, input logic [15:0] et, input int plen, input bit counting);
    logic [31:0] f;
    frm.delete();
    for (int i = 5; i >= 0; i--) frm.push_back(dst[i*8 +: 8]);
    for (int i = 0; i < 6; i++)  frm.push_back(8'($urandom));
    frm.push_back(et[15:8]);
    frm.push_back(et[7:0]);
    for (int i = 0; i < plen; i++) frm.push_back(counting ? 8'(i) : 8'($urandom));
    f = fcs_of(frm, frm.size());
    frm.push_back(f[7:0]);
    frm.push_back(f[15:8]);
    frm.push_back(f[23:16]);
    frm.push_back(f[31:24]);
  endtask

  // Drive 7 preamble bytes, SFD, the frame, then two idle cycles; sample at negedge.
  task automatic run(input int er_idx, input int rst_idx);
    int total;
    int k;
    got_q.delete();
    ok_n = 0; err_n = 0; ok_at = -1; err_at = -1; et_at = 16'h0;
    total = 8 + frm.size() + 2;
    for (int i = 0; i < total; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.gmii_rx_er = 1'b0;
      if (i < 7) begin
        bus.gmii_rx_dv = 1'b1; bus.gmii_rxd = 8'h55;
      end else if (i == 7) begin
        bus.gmii_rx_dv = 1'b1; bus.gmii_rxd = 8'hD5;
      end else if (i < 8 + frm.size()) begin
        k = i - 8;
        bus.gmii_rx_dv = 1'b1;
        bus.gmii_rxd   = frm[k];
        bus.gmii_rx_er = (k == er_idx);
        rst            = (k == rst_idx);
      end else begin
        bus.gmii_rx_dv = 1'b0; bus.gmii_rxd = 8'h00;
      end
      @(negedge clk);
      if (bus.data_valid) got_q.push_back(bus.data_out);
      if (bus.data_frame_ready) begin ok_n++;  ok_at  = i; et_at = bus.eth_type; end
      if (bus.frame_err)        begin err_n++; err_at = i; et_at = bus.eth_type; end
      if (rst_idx >= 0 && i == 9 + rst_idx) begin
        check("rst_dv",   32'(bus.data_valid), 0);
        check("rst_type", 32'(bus.eth_type), 0);
        check("rst_pulse", 32'(bus.data_frame_ready | bus.frame_err), 0);
      end
    end
  endtask

  task automatic expect_frame(input string tag, input int er_idx, input int rst_idx);
    logic [47:0] dst;
    logic [31:0] fcs_rx;
    int          sz, plen, nb;
    bit          accepted, good;
    sz = frm.size();
    for (int i = 0; i < 6; i++) dst[(5-i)*8 +: 8] = frm[i];
    accepted = (dst == MAC) || (dst == BCAST);
    plen   = sz - 18;
    fcs_rx = {frm[sz-1], frm[sz-2], frm[sz-3], frm[sz-4]};
    good   = (fcs_of(frm, sz - 4) == fcs_rx) && (sz >= 64) && (er_idx < 0) && (plen <= MAXP);
    if (rst_idx >= 0)   nb = (rst_idx > 18) ? rst_idx - 18 : 0;
    else if (!accepted) nb = 0;
    else                nb = (plen < MAXP) ? plen : MAXP;

    check({tag, "_beats"}, got_q.size(), nb);
    for (int j = 0; j < nb && j < got_q.size(); j++)
      check({tag, "_data"}, got_q[j], frm[14 + j]);

    if (rst_idx >= 0 || !accepted) begin
      check({tag, "_ok_n"}, ok_n, 0);
      check({tag, "_err_n"}, err_n, 0);
    end else if (good) begin
      check({tag, "_ok_n"}, ok_n, 1);
      check({tag, "_err_n"}, err_n, 0);
      check({tag, "_ok_at"}, ok_at, 9 + sz);
      check({tag, "_type"}, et_at, {frm[12], frm[13]});
    end else begin
      check({tag, "_ok_n"}, ok_n, 0);
      check({tag, "_err_n"}, err_n, 1);
      check({tag, "_err_at"}, err_at, 9 + sz);
      check({tag, "_type"}, et_at, {frm[12], frm[13]});
    end
  endtask

  initial begin
    int plen, er, pick;
    logic [47:0] dst;
    rst = 1'b1;
    bus.gmii_rx_dv = 1'b0;
    bus.gmii_rx_er = 1'b0;
    bus.gmii_rxd   = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_dv",    32'(bus.data_valid), 0);
    check("reset_data",  32'(bus.data_out), 0);
    check("reset_ready", 32'(bus.data_frame_ready), 0);
    check("reset_err",   32'(bus.frame_err), 0);
    check("reset_type",  32'(bus.eth_type), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    build(MAC, 16'h0800, 46, 1'b1);
    run(-1, -1); expect_frame("good", -1, -1);

    frm[frm.size()-4] ^= 8'h01;
    run(-1, -1); expect_frame("badfcs", -1, -1);

    build(OTHER, 16'h0800, 46, 1'b1);
    run(-1, -1); expect_frame("wrongdst", -1, -1);

    build(BCAST, 16'h0806, 46, 1'b1);
    run(-1, -1); expect_frame("bcast", -1, -1);

    build(MAC, 16'h0800, 20, 1'b1);
    run(-1, -1); expect_frame("runt", -1, -1);

    build(MAC, 16'h0800, 46, 1'b0);
    run(24, -1); expect_frame("rxer", 24, -1);

    build(MAC, 16'h86DD, 1600, 1'b0);
    run(-1, -1); expect_frame("oversize", -1, -1);

    build(MAC, 16'h0800, 46, 1'b1);
    run(-1, 44); expect_frame("midrst", -1, 44);
    build(MAC, 16'h0801, 50, 1'b0);
    run(-1, -1); expect_frame("afterrst", -1, -1);

    for (int n = 0; n < 16; n++) begin
      pick = $urandom_range(0, 3);
      dst  = (pick == 0) ? OTHER : (pick == 1) ? BCAST : MAC;
      plen = $urandom_range(20, 90);
      build(dst, 16'($urandom), plen, 1'b0);
      if ($urandom_range(0, 3) == 0) frm[frm.size() - 1 - $urandom_range(0, 3)] ^= 8'h10;
      er = ($urandom_range(0, 5) == 0) ? $urandom_range(6, frm.size() - 1) : -1;
      run(er, -1); expect_frame("rand", er, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
